// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e  : IDLE / REQ / DONE transaction states
//   LOAD, STORE  : RV32I opcodes handled by the unit
//   LB..SW       : funct3 encodings for access size/signedness
//   access_ok()  : funct3 legality plus natural-alignment check
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_e;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

  // Unsigned variants (funct3[2]=1) exist only for loads.
  function automatic logic access_ok(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~addr_lo[0];
      3'd2:    ok = (addr_lo == 2'b00);
      3'd4:    ok = ~is_store;
      3'd5:    ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   access size / signedness
//   is_store  in  1   1 = store, 0 = load
//   wr_data   in  32  store data (rs2)
//   rd_data   in  32  raw bus read word
//   byte_en   out 4   byte-lane enables
//   wdata     out 32  lane-replicated store data
//   load_ext  out 32  extracted and extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  always_comb begin
    byte_en  = 4'b1111;
    wdata    = wr_data;
    load_ext = rd_data;
    // Bring the addressed lane down to bit 0.
    shifted  = rd_data >> {addr_lo, 3'b000};

    if (is_store) begin
      case (funct3)
        SB: begin
          byte_en = 4'b0001 << addr_lo;
          wdata   = {4{wr_data[7:0]}};
        end
        SH: begin
          byte_en = 4'b0011 << addr_lo;
          wdata   = {2{wr_data[15:0]}};
        end
        default: byte_en = 4'b1111;
      endcase
    end

    case (funct3)
      LB:      load_ext = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_ext = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_ext = {24'h0, shifted[7:0]};
      LHU:     load_ext = {16'h0, shifted[15:0]};
      default: load_ext = rd_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding data-memory access unit for RV32I.
// Accepts a load/store from execute, runs one req/ack bus transaction and
// returns extended load data with a one-cycle done pulse.
//   clk, rst (async, active-low)
//   ex_valid, opcode, funct3, read_address, write_address, store_data : execute side
//   mem_rdata, mem_ack                                                : bus inputs
//   mem_addr, mem_wdata, mem_byte_en, mem_read, mem_write             : bus outputs
//   load_data, done, err, busy                                        : writeback / stall
// Optional build macro LSU_TIMEOUT_EN adds a REQ watchdog of TIMEOUT_CYCLES cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] read_address,
  input  logic [31:0] write_address,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] load_data,
  output logic        done,
  output logic        err,
  output logic        busy
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_store_q, is_store_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] load_data_q, load_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  logic        in_load, in_store;
  logic [31:0] acc_addr;
  logic        legal;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic        al_is_store;
  logic [3:0]  al_byte_en;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign in_load  = (opcode == LOAD);
  assign in_store = (opcode == STORE);
  assign acc_addr = in_store ? write_address : read_address;
  assign legal    = access_ok(in_store, funct3, acc_addr[1:0]);

  // The single lane unit serves the incoming instruction at acceptance and
  // the registered access while waiting for the ack.
  assign al_addr_lo  = (state_q == REQ) ? addr_lo_q  : acc_addr[1:0];
  assign al_funct3   = (state_q == REQ) ? funct3_q   : funct3;
  assign al_is_store = (state_q == REQ) ? is_store_q : in_store;

  lsu_align u_align (
    .addr_lo  (al_addr_lo),
    .funct3   (al_funct3),
    .is_store (al_is_store),
    .wr_data  (store_data),
    .rd_data  (mem_rdata),
    .byte_en  (al_byte_en),
    .wdata    (al_wdata),
    .load_ext (al_load)
  );

  always_comb begin
    state_d       = state_q;
    addr_lo_d     = addr_lo_q;
    funct3_d      = funct3_q;
    is_store_d    = is_store_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    load_data_d   = load_data_q;
    err_d         = err_q;
    done_d        = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      // DONE shares IDLE's acceptance so a new access can start on the
      // edge that leaves DONE.
      IDLE, DONE: begin
        state_d = IDLE;
        if (ex_valid && (in_load || in_store)) begin
          addr_lo_d   = acc_addr[1:0];
          funct3_d    = funct3;
          is_store_d  = in_store;
          load_data_d = '0;
          err_d       = ~legal;
          if (legal) begin
            state_d       = REQ;
            mem_addr_d    = {acc_addr[31:2], 2'b00};
            mem_wdata_d   = al_wdata;
            mem_byte_en_d = in_store ? al_byte_en : 4'b1111;
            mem_read_d    = in_load;
            mem_write_d   = in_store;
`ifdef LSU_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d     = DONE;
          done_d      = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b0;
          load_data_d = is_store_q ? '0 : al_load;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          done_d      = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_lo_q     <= '0;
      funct3_q      <= '0;
      is_store_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      load_data_q   <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_lo_q     <= addr_lo_d;
      funct3_q      <= funct3_d;
      is_store_q    <= is_store_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      load_data_q   <= load_data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign load_data   = load_data_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit with a
// behavioural access model (lane math done arithmetically).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, store_data, mem_rdata;
  logic        mem_ack;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_byte_en;
  logic        mem_read, mem_write, done, err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
    .read_address(read_address), .write_address(write_address), .store_data(store_data),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_read(mem_read), .mem_write(mem_write),
    .load_data(load_data), .done(done), .err(err), .busy(busy)
  );

  // Reference model: legality, lanes and load value from size/offset arithmetic.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] rd, output bit e,
                                output logic [3:0] be, output logic [31:0] wd, output logic [31:0] ld);
    int unsigned off, size;
    logic [31:0] mask, v;
    off  = addr % 4;
    size = 1 << (f3 % 4);
    e = 0;
    if (st && f3 > 2) e = 1;
    if (!st && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1;
    if (!e && (addr % size) != 0) e = 1;
    be = st ? 4'(((32'd1 << size) - 1) << off) : 4'hF;
    wd = (size == 1) ? sd[7:0] * 32'h01010101 : (size == 2) ? sd[15:0] * 32'h00010001 : sd;
    mask = (size >= 4) ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 1;
    v = (rd >> (8 * off)) & mask;
    if (!e && f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
    ld = (e || st) ? 32'h0 : v;
  endfunction

  // Presents one instruction for a single cycle; called at a negedge with the unit idle.
  task automatic start(input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd);
    ex_valid      = 1'b1;
    opcode        = st ? 7'b0100011 : 7'b0000011;
    funct3        = f3;
    read_address  = st ? $urandom : addr;
    write_address = st ? addr : $urandom;
    store_data    = sd;
    @(negedge clk);
    ex_valid = 1'b0;
    opcode   = 7'($urandom);
  endtask

  task automatic test_transaction(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rd, input int d, input string tag);
    bit e;
    logic [3:0] be;
    logic [31:0] wd, ld;
    model(st, f3, addr, sd, rd, e, be, wd, ld);
    start(st, f3, addr, sd);
    if (e) begin
      checks++;
      if ({done, err, load_data, mem_read, mem_write} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s illegal: done=%b err=%b load_data=%h rd=%b wr=%b, required done=1 err=1 load_data=0 rd=0 wr=0",
                 tag, done, err, load_data, mem_read, mem_write);
      end
    end else begin
      checks++;
      if ({mem_read, mem_write, mem_addr, mem_byte_en, done, busy} !==
          {!st, st, {addr[31:2], 2'b00}, be, 1'b0, 1'b1} || (st && mem_wdata !== wd)) begin
        errors++;
        $display("FAIL %s request: rd=%b wr=%b addr=%h be=%b wdata=%h done=%b busy=%b, required rd=%b wr=%b addr=%h be=%b wdata=%h done=0 busy=1",
                 tag, mem_read, mem_write, mem_addr, mem_byte_en, mem_wdata, done, busy,
                 !st, st, {addr[31:2], 2'b00}, be, wd);
      end
      for (int k = 0; k < d; k++) begin
        mem_rdata = $urandom;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || mem_read !== !st || mem_write !== st || mem_addr !== {addr[31:2], 2'b00}) begin
          errors++;
          $display("FAIL %s hold: done=%b rd=%b wr=%b addr=%h, required done=0 rd=%b wr=%b addr=%h",
                   tag, done, mem_read, mem_write, mem_addr, !st, st, {addr[31:2], 2'b00});
        end
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      checks++;
      if ({done, err, load_data, mem_read, mem_write, busy} !== {1'b1, 1'b0, ld, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL %s done: done=%b err=%b load_data=%h rd=%b wr=%b busy=%b, required done=1 err=0 load_data=%h rd=0 wr=0 busy=1",
                 tag, done, err, load_data, mem_read, mem_write, busy, ld);
      end
    end
    @(negedge clk);
    checks++;
    if ({done, busy, load_data, err} !== {1'b0, 1'b0, ld, e}) begin
      errors++;
      $display("FAIL %s after: done=%b busy=%b load_data=%h err=%b, required done=0 busy=0 load_data=%h err=%b",
               tag, done, busy, load_data, err, ld, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_addr, mem_wdata, mem_byte_en, mem_read, mem_write, load_data, done, err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: addr=%h wdata=%h be=%b rd=%b wr=%b ld=%h done=%b err=%b busy=%b, required all 0",
               mem_addr, mem_wdata, mem_byte_en, mem_read, mem_write, load_data, done, err, busy);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stores();
    test_transaction(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, $urandom, 3, "sw_0x100");
    test_transaction(1'b1, 3'd0, 32'h103, 32'h000000A5, $urandom, 0, "sb_0x103");
    test_transaction(1'b1, 3'd1, 32'h202, 32'h1234BEEF, $urandom, 1, "sh_0x202");
  endtask

  task automatic test_loads();
    test_transaction(1'b0, 3'd0, 32'h102, 32'h0, 32'h00F00000, 0, "lb_0x102");
    checks++;
    if (load_data !== 32'hFFFFFFF0) begin
      errors++;
      $display("FAIL lb_value: load_data=%h, required FFFFFFF0", load_data);
    end
    test_transaction(1'b0, 3'd4, 32'h102, 32'h0, 32'h00F00000, 2, "lbu_0x102");
    checks++;
    if (load_data !== 32'h000000F0) begin
      errors++;
      $display("FAIL lbu_value: load_data=%h, required 000000F0", load_data);
    end
    test_transaction(1'b0, 3'd1, 32'h102, 32'h0, 32'h80010000, 1, "lh_0x102");
    checks++;
    if (load_data !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_value: load_data=%h, required FFFF8001", load_data);
    end
    test_transaction(1'b0, 3'd5, 32'h100, 32'h0, 32'h1234F00D, 0, "lhu_0x100");
    test_transaction(1'b0, 3'd2, 32'h104, 32'h0, 32'hCAFEF00D, 1, "lw_0x104");
  endtask

  task automatic test_misaligned();
    test_transaction(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, "lw_0x101");
    test_transaction(1'b1, 3'd1, 32'h103, 32'hFFFF, 32'h0, 0, "sh_0x103");
    test_transaction(1'b0, 3'd5, 32'h101, 32'h0, 32'h0, 0, "lhu_0x101");
    test_transaction(1'b1, 3'd2, 32'h102, 32'h1, 32'h0, 0, "sw_0x102");
    test_transaction(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, "load_f3_3");
    test_transaction(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0, "store_f3_4");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    start(1'b0, 3'd2, 32'h200, 32'h0);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_req: mem_read=%b, required 1", mem_read);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop: mem_read=%b busy=%b, required 0 0", mem_read, busy);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1;
    end
    checks++;
    if (saw_done || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: saw_done=%b busy=%b, required 0 0", saw_done, busy);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] r;
    r = $urandom;
    start(1'b0, 3'd2, 32'h300, 32'h0);
    ex_valid = 1'b1; opcode = 7'b0100011; funct3 = 3'd2;
    write_address = 32'h400; read_address = 32'h404; store_data = $urandom;
    @(negedge clk);
    ex_valid = 1'b0;
    checks++;
    if (mem_addr !== 32'h300 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_req: addr=%h rd=%b wr=%b, required 00000300 1 0", mem_addr, mem_read, mem_write);
    end
    mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || load_data !== r) begin
      errors++;
      $display("FAIL busy_ignore_done: done=%b load_data=%h, required 1 %h", done, load_data, r);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_idle: busy=%b wr=%b done=%b, required 0 0 0", busy, mem_write, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit st;
      logic [2:0] f3;
      st = 1'($urandom_range(0, 1));
      if (st) f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      else    f3 = 3'($urandom_range(0, 7));
      test_transaction(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), "random");
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    start(1'b0, 3'd2, 32'h500, 32'h0);
    while (mem_read === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4 || done !== 1'b1 || err !== 1'b1 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d done=%b err=%b load_data=%h, required 4 1 1 00000000",
               n, done, err, load_data);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0; ex_valid = 1'b0; opcode = '0; funct3 = '0;
    read_address = '0; write_address = '0; store_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_stores();
    test_loads();
    test_misaligned();
    test_reset_mid();
    test_busy_ignore();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
